// File: rtl/spram_arbiter.sv
// Two-port arbiter in front of a single-port memory. A pending requester is
// latched as owner, gets exactly one memory strobe, then waits for mem_done or
// a timeout. Completion and timeout are reported as one-cycle pulses.
module spram_arbiter #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned FAIR    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_ren,
  input  logic        p0_wen,
  input  logic [3:0]  p0_wmask,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic [31:0] p0_rdata,
  output logic        p0_done,
  output logic        p0_err,
  input  logic        p1_ren,
  input  logic        p1_wen,
  input  logic [3:0]  p1_wmask,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic [31:0] p1_rdata,
  output logic        p1_done,
  output logic        p1_err,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_done,
  output logic        busy,
  output logic [1:0]  grant
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_e      state;
  logic        owner;     // 0 = port 0, 1 = port 1
  logic        last;      // port that completed most recently
  logic [7:0]  cnt;

  logic        pend0, pend1;
  logic        win;
  logic        win_ren, win_wen;
  logic [3:0]  own_wmask;
  logic [31:0] own_addr, own_wdata;

  assign pend0 = p0_ren | p0_wen;
  assign pend1 = p1_ren | p1_wen;

  // Pick the winner among pending ports; a tie goes to the port not served last
  always_comb begin
    win = 1'b0;
    if (pend0 && pend1) begin
      win = (FAIR != 0) ? ~last : 1'b0;
    end else begin
      win = ~pend0;
    end
    win_ren = win ? p1_ren : p0_ren;
    win_wen = win ? p1_wen : p0_wen;
  end

  // Owner operand mux
  always_comb begin
    own_wmask = owner ? p1_wmask : p0_wmask;
    own_addr  = owner ? p1_addr  : p0_addr;
    own_wdata = owner ? p1_wdata : p0_wdata;
  end

  // Memory-side operands mirror the owner while busy, zero when idle
  always_comb begin
    busy      = (state != StIdle);
    grant     = 2'b00;
    mem_wmask = 4'h0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    if (state != StIdle) begin
      grant     = owner ? 2'b10 : 2'b01;
      mem_wmask = own_wmask;
      mem_addr  = own_addr;
      mem_wdata = own_wdata;
    end
  end

  // Control FSM with registered strobes, pulses and read data
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= StIdle;
      owner    <= 1'b0;
      last     <= 1'b1;
      cnt      <= 8'h0;
      p0_rdata <= 32'h0;
      p1_rdata <= 32'h0;
      p0_done  <= 1'b0;
      p1_done  <= 1'b0;
      p0_err   <= 1'b0;
      p1_err   <= 1'b0;
      mem_ren  <= 1'b0;
      mem_wen  <= 1'b0;
    end else begin
      p0_done <= 1'b0;
      p1_done <= 1'b0;
      p0_err  <= 1'b0;
      p1_err  <= 1'b0;
      mem_ren <= 1'b0;
      mem_wen <= 1'b0;
      unique case (state)
        StIdle: begin
          if (pend0 || pend1) begin
            owner   <= win;
            state   <= StIssue;
            // Strobe is registered so it is high for exactly the ISSUE cycle
            mem_wen <= win_wen;
            mem_ren <= win_ren & ~win_wen;
          end
        end
        StIssue: begin
          cnt   <= 8'h0;
          state <= StWait;
        end
        StWait: begin
          if (mem_done) begin
            if (owner) begin
              p1_rdata <= mem_rdata;
              p1_done  <= 1'b1;
            end else begin
              p0_rdata <= mem_rdata;
              p0_done  <= 1'b1;
            end
            last  <= owner;
            state <= StIdle;
          end else if (cnt == CntLast) begin
            if (owner) p1_err <= 1'b1;
            else       p0_err <= 1'b1;
            last  <= owner;
            state <= StIdle;
          end else begin
            cnt <= cnt + 8'h1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
